// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding initiator for the 16-bit peripheral register bus
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_req_valid/o_req_ready         CPU request handshake (accepted only in IDLE)
//   i_req_we/i_req_addr/i_req_wdata request: [7:2] peripheral index, [1:0] register
//   o_rsp_valid/o_rsp_rdata/o_rsp_err  one-cycle response pulse; data/err hold until next response
//   o_sel/o_we/o_re/o_addr/o_wdata  peripheral bus drive (one-hot select)
//   i_rdata/i_rdy                   OR-combined peripheral read data and ready
module periph_bus_master #(
   parameter int N_PERIPH = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_we,
   input  logic [7:0]          i_req_addr,
   input  logic [15:0]         i_req_wdata,
   output logic                o_rsp_valid,
   output logic [15:0]         o_rsp_rdata,
   output logic                o_rsp_err,
   output logic [N_PERIPH-1:0] o_sel,
   output logic                o_we,
   output logic                o_re,
   output logic [1:0]          o_addr,
   output logic [15:0]         o_wdata,
   input  logic [15:0]         i_rdata,
   input  logic                i_rdy
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [5:0]      idx;
   logic            idx_ok;
   assign idx         = i_req_addr[7:2];
   assign idx_ok      = {1'b0, idx} < 7'(N_PERIPH);
   assign o_req_ready = state == IDLE;
   assign o_rsp_valid = state == RESP;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         o_sel       <= '0;
         o_we        <= 1'b0;
         o_re        <= 1'b0;
         o_addr      <= '0;
         o_wdata     <= '0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_req_valid) begin
               o_addr  <= i_req_addr[1:0];
               o_wdata <= i_req_wdata;
               cnt     <= '0;
               if (idx_ok) begin
                  state <= ACCESS;
                  o_sel <= N_PERIPH'(1) << idx;
                  o_we  <= i_req_we;
                  o_re  <= !i_req_we;
               end else begin
                  // decode error skips the bus entirely
                  state       <= RESP;
                  o_rsp_rdata <= '0;
                  o_rsp_err   <= 1'b1;
               end
            end
            ACCESS: begin
               // ready in the last allowed cycle still wins over the timeout
               if (i_rdy || cnt == CW'(TIMEOUT - 1)) begin
                  state       <= RESP;
                  o_sel       <= '0;
                  o_we        <= 1'b0;
                  o_re        <= 1'b0;
                  o_rsp_rdata <= (i_rdy && o_re) ? i_rdata : '0;
                  o_rsp_err   <= !i_rdy;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: randomized + directed check of periph_bus_master against a transaction-level model
module tb_periph_bus_master;
   localparam int N  = 4;
   localparam int TO = 16;
   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_req_valid = 1'b0;
   logic          o_req_ready;
   logic          i_req_we = 1'b0;
   logic [7:0]    i_req_addr = '0;
   logic [15:0]   i_req_wdata = '0;
   logic          o_rsp_valid;
   logic [15:0]   o_rsp_rdata;
   logic          o_rsp_err;
   logic [N-1:0]  o_sel;
   logic          o_we;
   logic          o_re;
   logic [1:0]    o_addr;
   logic [15:0]   o_wdata;
   logic [15:0]   i_rdata;
   logic          i_rdy;
   int            n_vec = 0;
   int            n_err = 0;
   int            lat = 0;
   int            acc_n = 0;
   logic [15:0]   pmem [N][4];
   logic [15:0]   ref_mem [N][4];
   logic [15:0]   rd_or;

   periph_bus_master #(.N_PERIPH(N), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_sel(o_sel), .o_we(o_we), .o_re(o_re), .o_addr(o_addr), .o_wdata(o_wdata),
      .i_rdata(i_rdata), .i_rdy(i_rdy)
   );

   always #5 i_clk = ~i_clk;

   // bench peripherals: ready on the lat-th selected cycle (lat=0 never), register file per peripheral
   always @(posedge i_clk) acc_n <= (|o_sel) ? acc_n + 1 : 0;
   assign i_rdy = (|o_sel) && lat != 0 && acc_n + 1 == lat;
   always_comb begin
      rd_or = '0;
      for (int p = 0; p < N; p++) if (o_sel[p]) rd_or = rd_or | pmem[p][o_addr];
   end
   assign i_rdata = (o_re && i_rdy) ? rd_or : '0;
   always @(posedge i_clk)
      for (int p = 0; p < N; p++) if (o_sel[p] && o_we && i_rdy) pmem[p][o_addr] <= o_wdata;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wd, input int l);
      int w;
      w = 0;
      while (!o_req_ready && w < 20) begin
         @(posedge i_clk); #1; w++;
      end
      chk("req_ready_before_issue", o_req_ready, 1);
      lat = l;
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wd;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      // scramble request fields so latching is exercised
      i_req_we = 1'($urandom); i_req_addr = 8'($urandom); i_req_wdata = 16'($urandom);
   endtask

   task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wd, input int l);
      int idx, n;
      logic ok, e;
      logic [15:0] rd;
      idx = int'(addr[7:2]);
      ok  = idx < N;
      e   = !ok || l == 0 || l > TO;
      n   = (l != 0 && l <= TO) ? l : TO;
      rd  = (ok && !we && !e) ? ref_mem[idx][addr[1:0]] : 16'h0;
      if (ok && we && !e) ref_mem[idx][addr[1:0]] = wd;
      issue(we, addr, wd, l);
      if (ok) begin
         for (int c = 1; c <= n; c++) begin
            if (c > 1) begin
               @(posedge i_clk); #1;
            end
            chk("acc_sel", o_sel, 64'(N'(1) << idx));
            chk("acc_we", o_we, we);
            chk("acc_re", o_re, !we);
            chk("acc_addr", o_addr, addr[1:0]);
            chk("acc_wdata", o_wdata, wd);
            chk("acc_ready", o_req_ready, 0);
            chk("acc_rsp_valid", o_rsp_valid, 0);
         end
         @(posedge i_clk); #1;
      end
      chk("rsp_valid", o_rsp_valid, 1);
      chk("rsp_rdata", o_rsp_rdata, rd);
      chk("rsp_err", o_rsp_err, e);
      chk("rsp_sel", o_sel, 0);
      chk("rsp_strobes", {o_we, o_re}, 0);
      chk("rsp_ready", o_req_ready, 0);
      @(posedge i_clk); #1;
      chk("idle_rsp_valid", o_rsp_valid, 0);
      chk("idle_ready", o_req_ready, 1);
      chk("idle_rdata_held", o_rsp_rdata, rd);
      chk("idle_err_held", o_rsp_err, e);
   endtask

   initial begin
      for (int p = 0; p < N; p++)
         for (int r = 0; r < 4; r++) begin
            pmem[p][r]    = 16'($urandom);
            ref_mem[p][r] = pmem[p][r];
         end
      pmem[1][3] = 16'hBEEF;
      ref_mem[1][3] = 16'hBEEF;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      chk("reset_ready", o_req_ready, 1);
      chk("reset_rsp_valid", o_rsp_valid, 0);
      chk("reset_rsp_rdata", o_rsp_rdata, 0);
      chk("reset_rsp_err", o_rsp_err, 0);
      chk("reset_bus", {o_sel, o_we, o_re, o_addr, o_wdata}, 0);
      // timer write then read back, wait-state read, timeout, timeout boundary, decode error
      txn(1'b1, 8'h02, 16'h1234, 1);
      txn(1'b0, 8'h02, 16'h0000, 1);
      txn(1'b0, 8'h07, 16'h0000, 3);
      txn(1'b0, 8'h08, 16'h0000, 0);
      txn(1'b0, 8'h08, 16'h0000, TO);
      txn(1'b1, 8'h08, 16'h5A5A, TO + 1);
      txn(1'b0, 8'h10, 16'h0000, 1);
      txn(1'b1, 8'hFC, 16'hFFFF, 1);
      // reset during the second wait cycle of a stalled read
      issue(1'b0, 8'h08, 16'h0000, 0);
      chk("rst_pre_sel", o_sel, 64'h4);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      chk("rst_sel", o_sel, 0);
      chk("rst_strobes", {o_we, o_re}, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_ready", o_req_ready, 1);
      @(posedge i_clk); #1;
      chk("rst_no_pulse", o_rsp_valid, 0);
      txn(1'b0, 8'h07, 16'h0000, 2);
      for (int k = 0; k < 60; k++) begin
         logic [7:0] a;
         int l;
         a = {3'b000, 3'($urandom_range(0, 4)), 2'($urandom)};
         l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 2)) : int'($urandom_range(1, 4));
         txn(1'($urandom), a, 16'($urandom), l);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
